// File: rtl/anc_pkg.sv
// Shared state encoding and Q1.15 constants for the ANC per-sample sequencer.
package anc_pkg;

  localparam int Q15_W = 16;
  localparam logic [Q15_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [Q15_W-1:0] Q15_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LATCH,
    ST_GO,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/bw_mult.sv
// Signed AW x BW multiplier producing the full-precision product.
module bw_mult #(
  parameter int AW = 16,
  parameter int BW = 16
) (
  input  logic signed [AW-1:0]    i_a,
  input  logic signed [BW-1:0]    i_b,
  output logic signed [AW+BW-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/saturate.sv
// Clamp a signed IW-bit value into a signed OW-bit range.
module saturate #(
  parameter int IW = 17,
  parameter int OW = 16
) (
  input  logic [IW-1:0] i_d,
  output logic [OW-1:0] o_q
);

  logic [IW-OW:0] w_hi;
  logic           w_fits;

  // The value fits when every bit above the output sign bit matches it.
  assign w_hi   = i_d[IW-1:OW-1];
  assign w_fits = (w_hi == '0) || (w_hi == '1);

  assign o_q = w_fits    ? i_d[OW-1:0] :
               i_d[IW-1] ? {1'b1, {(OW-1){1'b0}}} :
                           {1'b0, {(OW-1){1'b1}}};

endmodule

// File: rtl/anc_sample_ctrl.sv
// Per-sample sequencer: capture ADC samples, form mu*e, run one FIR pass,
// and hand the result to the DAC while policing overruns and FIR hangs.
module anc_sample_ctrl
  import anc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 300,
  parameter int TW          = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_enable,
  input  logic [Q15_W-1:0] i_mu,
  input  logic             i_err_clr,
  input  logic             i_sample_valid,
  input  logic [Q15_W-1:0] i_x_sample,
  input  logic [Q15_W-1:0] i_e_sample,
  input  logic [Q15_W-1:0] i_a_sample,
  output logic [Q15_W-1:0] o_fir_x_in,
  output logic [Q15_W-1:0] o_fir_a_in,
  output logic [Q15_W-1:0] o_fir_weight_adjust,
  output logic             o_fir_go,
  input  logic             i_fir_done,
  input  logic [Q15_W-1:0] i_fir_out_sample,
  output logic [Q15_W-1:0] o_dac_data,
  output logic             o_dac_valid,
  input  logic             i_dac_ready,
  output logic             o_busy,
  output logic [7:0]       o_overrun_cnt,
  output logic             o_dac_ovf,
  output logic             o_timeout_err
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_capture;
  logic               w_done_ok;
  logic               w_timeout;
  logic               w_overrun;
  logic               w_ovf_set;

  logic [Q15_W-1:0]   r_x_in;
  logic [Q15_W-1:0]   r_a_in;
  logic [Q15_W-1:0]   r_e_reg;
  logic [Q15_W-1:0]   r_wadj;
  logic               r_fir_go;
  logic [TW-1:0]      r_tmo_cnt;
  logic [TW-1:0]      w_cnt_inc;
  logic [Q15_W-1:0]   r_dac_data;
  logic               r_dac_valid;
  logic [7:0]         r_overrun;
  logic               r_dac_ovf;
  logic               r_tmo_err;

  logic [2*Q15_W-1:0] w_prod;
  logic [Q15_W-1:0]   w_wadj;
  logic               w_unused_lsb;

  bw_mult #(.AW(Q15_W), .BW(Q15_W)) u_mult (
    .i_a (i_mu),
    .i_b (r_e_reg),
    .o_p (w_prod)
  );

  // Q1.15 x Q1.15 gives Q2.30; bits [31:15] are the Q1.15 result plus one guard bit.
  saturate #(.IW(Q15_W+1), .OW(Q15_W)) u_sat (
    .i_d (w_prod[2*Q15_W-1:Q15_W-1]),
    .o_q (w_wadj)
  );

  assign w_unused_lsb = ^w_prod[Q15_W-2:0];
  assign w_cnt_inc    = r_tmo_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_done_ok    = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_sample_valid && i_enable) begin
          w_capture    = 1'b1;
          w_next_state = ST_LATCH;
        end
      end
      ST_LATCH: w_next_state = ST_GO;
      ST_GO:    w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (i_fir_done) begin
          w_done_ok    = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_cnt_inc == TW'(TIMEOUT_CYC - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_overrun = i_sample_valid && i_enable && (r_state != ST_IDLE);
  assign w_ovf_set = w_done_ok && r_dac_valid && !i_dac_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_in    <= '0;
      r_a_in    <= '0;
      r_e_reg   <= '0;
      r_wadj    <= '0;
      r_fir_go  <= 1'b0;
      r_tmo_cnt <= '0;
    end else begin
      r_fir_go <= (w_next_state == ST_GO);
      if (w_capture) begin
        r_x_in  <= i_x_sample;
        r_a_in  <= i_a_sample;
        r_e_reg <= i_e_sample;
      end
      if (r_state == ST_LATCH) r_wadj <= w_wadj;
      if (r_state == ST_GO)        r_tmo_cnt <= '0;
      else if (r_state == ST_WAIT) r_tmo_cnt <= w_cnt_inc;
    end
  end

  // A reload on fir_done takes priority over a same-cycle DAC accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dac_data  <= '0;
      r_dac_valid <= 1'b0;
    end else if (w_done_ok) begin
      r_dac_data  <= i_fir_out_sample;
      r_dac_valid <= 1'b1;
    end else if (r_dac_valid && i_dac_ready) begin
      r_dac_valid <= 1'b0;
    end
  end

  // Sticky flags: a set event in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= '0;
      r_dac_ovf <= 1'b0;
      r_tmo_err <= 1'b0;
    end else begin
      if (w_overrun) begin
        if (r_overrun != 8'hFF) r_overrun <= r_overrun + 8'd1;
      end else if (i_err_clr) begin
        r_overrun <= '0;
      end
      if (i_err_clr) r_dac_ovf <= 1'b0;
      if (w_ovf_set) r_dac_ovf <= 1'b1;
      if (i_err_clr) r_tmo_err <= 1'b0;
      if (w_timeout) r_tmo_err <= 1'b1;
    end
  end

  assign o_fir_x_in          = r_x_in;
  assign o_fir_a_in          = r_a_in;
  assign o_fir_weight_adjust = r_wadj;
  assign o_fir_go            = r_fir_go;
  assign o_dac_data          = r_dac_data;
  assign o_dac_valid         = r_dac_valid;
  assign o_busy              = (r_state != ST_IDLE);
  assign o_overrun_cnt       = r_overrun;
  assign o_dac_ovf           = r_dac_ovf;
  assign o_timeout_err       = r_tmo_err;

endmodule

// File: tb/tb_anc_sample_ctrl.sv
// Bench for anc_sample_ctrl: vector table for the weight-adjust path, a DAC
// scoreboard, an FIR stand-in, and hand sequences for the multi-cycle cases.
module tb_anc_sample_ctrl;

  typedef struct {
    logic [15:0] mu;
    logic [15:0] e;
    logic [15:0] x;
    logic [15:0] a;
    logic [15:0] expWadj;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN, enable, errClr, sampleValid, dacReady, firDone;
  logic [15:0] mu, xSample, eSample, aSample, firOutSample;
  logic [15:0] firXIn, firAIn, firWadj, dacData;
  logic        firGo, dacValid, busy, dacOvf, timeoutErr;
  logic [7:0]  overrunCnt;

  int          nChecks = 0;
  int          nErrors = 0;
  int          goCount = 0;
  int          firCnt = 0;
  bit          firRespond = 1'b1;
  logic [15:0] sbQueue[$];
  vec_t        vecs[6];

  always #5 clk = ~clk;

  anc_sample_ctrl #(.TIMEOUT_CYC(300), .TW(9)) dut (
    .clk                 (clk),
    .rst_n               (rstN),
    .i_enable            (enable),
    .i_mu                (mu),
    .i_err_clr           (errClr),
    .i_sample_valid      (sampleValid),
    .i_x_sample          (xSample),
    .i_e_sample          (eSample),
    .i_a_sample          (aSample),
    .o_fir_x_in          (firXIn),
    .o_fir_a_in          (firAIn),
    .o_fir_weight_adjust (firWadj),
    .o_fir_go            (firGo),
    .i_fir_done          (firDone),
    .i_fir_out_sample    (firOutSample),
    .o_dac_data          (dacData),
    .o_dac_valid         (dacValid),
    .i_dac_ready         (dacReady),
    .o_busy              (busy),
    .o_overrun_cnt       (overrunCnt),
    .o_dac_ovf           (dacOvf),
    .o_timeout_err       (timeoutErr)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] m, input logic [15:0] e,
                               input logic [15:0] x, input logic [15:0] a);
    mu          = m;
    eSample     = e;
    xSample     = x;
    aSample     = a;
    sampleValid = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_x_in"},     32'(firXIn),     32'd0);
    checkOutput({tag, "_a_in"},     32'(firAIn),     32'd0);
    checkOutput({tag, "_wadj"},     32'(firWadj),    32'd0);
    checkOutput({tag, "_go"},       32'(firGo),      32'd0);
    checkOutput({tag, "_dac_data"}, 32'(dacData),    32'd0);
    checkOutput({tag, "_dac_vld"},  32'(dacValid),   32'd0);
    checkOutput({tag, "_busy"},     32'(busy),       32'd0);
    checkOutput({tag, "_overrun"},  32'(overrunCnt), 32'd0);
    checkOutput({tag, "_dac_ovf"},  32'(dacOvf),     32'd0);
    checkOutput({tag, "_timeout"},  32'(timeoutErr), 32'd0);
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    if (busy) checkOutput("idle_wait_expired", 32'(busy), 32'd0);
  endtask

  // Drives one sample and follows it to completion; cycle 0 is the strobe cycle.
  task automatic runVector(input vec_t v, input bit pushExp, input bit checkLat);
    int n;
    int g0;
    g0 = goCount;
    if (pushExp) sbQueue.push_back(v.x + v.a);
    applyStimulus(v.mu, v.e, v.x, v.a);
    tick();
    sampleValid = 1'b0;
    checkOutput("go_cycle1", 32'(firGo), 32'd0);
    checkOutput("busy_cycle1", 32'(busy), 32'd1);
    tick();
    checkOutput("go_cycle2", 32'(firGo), 32'd1);
    checkOutput("weight_adjust", 32'(firWadj), 32'(v.expWadj));
    checkOutput("fir_x_in", 32'(firXIn), 32'(v.x));
    checkOutput("fir_a_in", 32'(firAIn), 32'(v.a));
    waitIdle(n);
    if (checkLat) checkOutput("go_to_dac_valid", 32'(n), 32'd264);
    checkOutput("dac_valid_at_idle", 32'(dacValid), 32'd1);
    checkOutput("go_count", 32'(goCount - g0), 32'd1);
    if (dacReady) begin
      tick();
      checkOutput("dac_valid_drain", 32'(dacValid), 32'd0);
    end
  endtask

  // FIR stand-in: done 263 cycles after go, result = x_in + a_in.
  initial begin
    firDone      = 1'b0;
    firOutSample = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstN) begin
        firCnt  = 0;
        firDone = 1'b0;
      end else begin
        firDone = 1'b0;
        if (firCnt > 0) begin
          firCnt--;
          if (firCnt == 0) begin
            firDone      = 1'b1;
            firOutSample = firXIn + firAIn;
          end
        end
        if (firGo && firRespond) firCnt = 263;
      end
    end
  end

  // Scoreboard and go counter, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] expData;
    if (rstN) begin
      if (firGo) goCount++;
      if (dacValid && dacReady) begin
        if (sbQueue.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("[TB] FAIL sb_unexpected: got dac_data 0x%0h, expected no transfer", dacData);
        end else begin
          expData = sbQueue.pop_front();
          checkOutput("sb_dac_data", 32'(dacData), 32'(expData));
        end
      end
    end
  end

  initial begin
    int n;
    int g0;
    vec_t v;

    vecs[0] = '{16'h4000, 16'h2000, 16'h1234, 16'h0100, 16'h1000};
    vecs[1] = '{16'h8000, 16'h8000, 16'h0001, 16'h0002, 16'h7FFF};
    vecs[2] = '{16'h7FFF, 16'h8000, 16'h7000, 16'h0FFF, 16'h8001};
    vecs[3] = '{16'hFFFF, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF};
    vecs[4] = '{16'h2000, 16'hC000, 16'h8000, 16'h8000, 16'hF000};
    vecs[5] = '{16'h0000, 16'h1234, 16'h5555, 16'h2222, 16'h0000};

    rstN = 1'b0; enable = 1'b1; errClr = 1'b0; sampleValid = 1'b0; dacReady = 1'b1;
    mu = '0; xSample = '0; eSample = '0; aSample = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rstN = 1'b1;
    tick();

    $display("[TB] vector table");
    foreach (vecs[i]) runVector(vecs[i], 1'b1, i == 0);

    $display("[TB] overrun during WAIT");
    g0 = goCount;
    sbQueue.push_back(16'h1133);
    applyStimulus(16'h4000, 16'h2000, 16'h1111, 16'h0022);
    tick(); sampleValid = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      sampleValid = 1'b1; tick();
      sampleValid = 1'b0; tick();
    end
    waitIdle(n);
    checkOutput("overrun_3", 32'(overrunCnt), 32'd3);
    checkOutput("overrun_go_count", 32'(goCount - g0), 32'd1);
    tick();
    errClr = 1'b1; tick(); errClr = 1'b0;
    checkOutput("overrun_cleared", 32'(overrunCnt), 32'd0);

    $display("[TB] timeout with overrun saturation");
    firRespond = 1'b0;
    g0 = goCount;
    applyStimulus(16'h4000, 16'h2000, 16'h0AAA, 16'h0000);
    tick(); sampleValid = 1'b0;
    tick();
    checkOutput("tmo_go", 32'(firGo), 32'd1);
    sampleValid = 1'b1;
    for (int c = 3; c <= 300; c++) tick();
    tick();
    sampleValid = 1'b0;
    checkOutput("tmo_not_yet", 32'(timeoutErr), 32'd0);
    checkOutput("tmo_busy_before", 32'(busy), 32'd1);
    checkOutput("overrun_saturated", 32'(overrunCnt), 32'd255);
    tick();
    checkOutput("tmo_set", 32'(timeoutErr), 32'd1);
    checkOutput("tmo_idle", 32'(busy), 32'd0);
    checkOutput("tmo_no_dac", 32'(dacValid), 32'd0);
    checkOutput("overrun_held", 32'(overrunCnt), 32'd255);
    repeat (3) tick();
    checkOutput("tmo_go_count", 32'(goCount - g0), 32'd1);
    errClr = 1'b1; tick(); errClr = 1'b0;
    checkOutput("tmo_cleared", 32'(timeoutErr), 32'd0);
    checkOutput("overrun_cleared2", 32'(overrunCnt), 32'd0);
    firRespond = 1'b1;
    runVector(vecs[0], 1'b1, 1'b0);

    $display("[TB] DAC backpressure");
    dacReady = 1'b0;
    v = '{16'h4000, 16'h2000, 16'h0AAA, 16'h0000, 16'h1000};
    runVector(v, 1'b0, 1'b0);
    checkOutput("bp_first_data", 32'(dacData), 32'h0AAA);
    checkOutput("bp_first_ovf", 32'(dacOvf), 32'd0);
    v = '{16'h4000, 16'h2000, 16'h0BBB, 16'h0000, 16'h1000};
    runVector(v, 1'b1, 1'b0);
    checkOutput("bp_second_data", 32'(dacData), 32'h0BBB);
    checkOutput("bp_second_valid", 32'(dacValid), 32'd1);
    checkOutput("bp_ovf", 32'(dacOvf), 32'd1);
    dacReady = 1'b1;
    tick();
    checkOutput("bp_drain", 32'(dacValid), 32'd0);

    $display("[TB] reset mid-WAIT");
    sbQueue.push_back(16'h3333);
    applyStimulus(16'h4000, 16'h2000, 16'h3333, 16'h0000);
    tick(); sampleValid = 1'b0;
    repeat (3) tick();
    sampleValid = 1'b1; tick(); sampleValid = 1'b0;
    repeat (10) tick();
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    checkOutput("pre_reset_overrun", 32'(overrunCnt), 32'd1);
    #2;
    rstN = 1'b0;
    sbQueue.delete();
    #1;
    checkAllZero("mid_reset");
    repeat (2) @(posedge clk);
    #2;
    rstN = 1'b1;
    tick();

    $display("[TB] sample with enable low");
    g0 = goCount;
    enable = 1'b0;
    applyStimulus(16'h4000, 16'h2000, 16'h4444, 16'h0000);
    tick(); sampleValid = 1'b0;
    repeat (4) tick();
    checkOutput("dis_busy", 32'(busy), 32'd0);
    checkOutput("dis_go_count", 32'(goCount - g0), 32'd0);
    checkOutput("dis_overrun", 32'(overrunCnt), 32'd0);
    checkOutput("dis_x_in", 32'(firXIn), 32'd0);
    enable = 1'b1;

    repeat (2) tick();
    checkOutput("sb_empty", 32'(sbQueue.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/anc_sample_ctrl.md
Name: anc_sample_ctrl

Overview:
- Per-sample sequencer for the adaptive FIR engine in the ANC datapath.
- Captures one reference/error/feedback sample set from the ADC front end and computes the LMS weight-adjust term mu*e.
- Launches one FIR pass, waits for completion and hands the anti-noise result to the DAC interface over a valid/ready handshake.
- Also polices overruns and FIR hangs.

Parameters:
- TIMEOUT_CYC, 300, max cycles from fir_go to fir_done before a timeout is declared. Must exceed the FIR pass latency of TAPS+7.
- TW, 9, width of the timeout counter, with 2^TW > TIMEOUT_CYC.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  accept new samples when high
- mu  in  16  step size, signed Q1.15
- err_clr  in  1  one-cycle pulse; clears sticky flags and counters
- sample_valid  in  1  one-cycle strobe; x_sample, e_sample and a_sample are valid
- x_sample  in  16  reference mic sample, signed Q1.15
- e_sample  in  16  error mic sample, signed Q1.15
- a_sample  in  16  feedback/bias term, signed Q1.15
- fir_x_in  out  16  to FIR x_in
- fir_a_in  out  16  to FIR a_in
- fir_weight_adjust  out  16  to FIR weight_adjust
- fir_go  out  1  one-cycle start pulse to FIR
- fir_done  in  1  FIR completion pulse
- fir_out_sample  in  16  FIR result, valid when fir_done is high
- dac_data  out  16  anti-noise sample
- dac_valid  out  1  dac_data valid
- dac_ready  in  1  DAC accepts when dac_valid and dac_ready are both high
- busy  out  1  state is not IDLE
- overrun_cnt  out  8  saturating count of dropped samples
- dac_ovf  out  1  sticky: unaccepted DAC word overwritten
- timeout_err  out  1  sticky: FIR failed to finish in time

Behaviour:
- Reset values: all outputs 0; state IDLE; capture registers 0.
- FSM states: IDLE, LATCH, GO, WAIT.
- IDLE:
  - On sample_valid && enable: register x_sample into fir_x_in, a_sample into fir_a_in and e_sample into e_reg; go to LATCH.
  - sample_valid with enable low is ignored and not counted.
- LATCH:
  - p = mu*e_reg, signed 32-bit.
  - fir_weight_adjust <= saturate(p[31:15]) to 16 bits; the only overflow case is 0x8000*0x8000, which gives 0x7FFF.
  - Go to GO.
- GO:
  - fir_go is a registered output, high for exactly this one cycle.
  - fir_go rises on the second clock edge after the sample_valid edge.
  - Timeout counter is cleared. Go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On fir_done: load dac_data <= fir_out_sample and set dac_valid; go to IDLE.
  - If the counter reaches TIMEOUT_CYC-1 without fir_done: set timeout_err, go to IDLE, no DAC update.
  - A late fir_done arriving in IDLE is ignored.
- fir_x_in, fir_a_in and fir_weight_adjust hold stable from LATCH exit until the next capture.
- DAC handshake:
  - dac_valid clears on a cycle with dac_valid && dac_ready.
  - On fir_done while dac_valid is high and dac_ready is low: overwrite dac_data, keep dac_valid high, set dac_ovf.
  - Accept and reload in the same cycle: reload wins (dac_valid stays 1), no ovf.
- Overrun:
  - sample_valid && enable while not IDLE drops the sample and increments overrun_cnt, saturating at 255.
  - No second fir_go is issued for the dropped sample.
- enable falling mid-operation: the current pass completes normally.
- err_clr: clears overrun_cnt, dac_ovf and timeout_err. Same cycle as a set event: the set wins.
- Asynchronous reset mid-WAIT: return to IDLE with outputs 0. The FIR is reset by the same rst_n.
- Throughput: one sample per TAPS+7+3 cycles minimum.

Decomposition:
- Shared package anc_pkg holds:
  - state enum (IDLE/LATCH/GO/WAIT)
  - Q15 width constant (16)
  - Q15 max/min constants (0x7FFF/0x8000)
- Sub-modules:
  - Reuse the existing saturate module (#(17,16)) for the weight-adjust term.
  - Reuse bw_mult for mu*e.
  - No other sub-modules.

Test Plan:
- Nominal pass, FIR model with done 263 cycles after go:
  - Stimulus: mu=0x4000, e=0x2000, x=0x1234, a=0x0100, sample_valid at cycle 0.
  - Response: fir_go only at cycle 2; weight_adjust=0x1000; fir_x_in=0x1234; fir_a_in=0x0100; dac_data=model value with dac_valid the cycle after done; busy drops.
- Saturation:
  - Stimulus: mu=0x8000, e=0x8000.
  - Response: weight_adjust=0x7FFF.
  - Stimulus: mu=0x7FFF, e=0x8000.
  - Response: weight_adjust=0x8001.
- Overrun:
  - Stimulus: three sample_valid pulses during WAIT.
  - Response: overrun_cnt=3, exactly one fir_go.
  - Stimulus: then err_clr.
  - Response: overrun_cnt=0.
  - Stimulus: a further 300 overruns.
  - Response: overrun_cnt holds at 255.
- Timeout:
  - Stimulus: FIR stub never asserts done, TIMEOUT_CYC=300.
  - Response: timeout_err set 300 cycles after fir_go; state IDLE; dac_valid stays 0.
  - Stimulus: a next sample.
  - Response: a new fir_go is issued.
- DAC backpressure:
  - Stimulus: dac_ready=0 across two passes, results 0x0AAA then 0x0BBB.
  - Response: dac_data=0x0BBB, dac_valid=1, dac_ovf=1.
  - Stimulus: dac_ready=1.
  - Response: dac_valid clears next cycle.
- Reset/enable:
  - Stimulus: rst_n low mid-WAIT.
  - Response: all outputs 0 immediately.
  - Stimulus: sample_valid with enable=0.
  - Response: no fir_go, overrun_cnt unchanged.
